// File: rtl/mac_pkg.sv
// Shared field positions and state encoding for the MAC receive packer.
// Byte entries come from the receive byte FIFO; word entries go to the clock-crossing FIFO.
package mac_pkg;

  localparam int unsigned BE_EOF = 10;
  localparam int unsigned BE_ERR = 9;
  localparam int unsigned BE_SOF = 8;

  localparam int unsigned WE_LAST    = 34;
  localparam int unsigned WE_BCNT_HI = 33;
  localparam int unsigned WE_BCNT_LO = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DROP
  } rx_state_e;

  function automatic logic [34:0] pack_word(input logic last, input logic [1:0] bcnt,
                                            input logic [31:0] data);
    logic [34:0] w;
    w                        = '0;
    w[WE_LAST]               = last;
    w[WE_BCNT_HI:WE_BCNT_LO] = bcnt;
    w[31:0]                  = data;
    return w;
  endfunction

endpackage

// File: rtl/mac_rx_packer.sv
// Receive-path byte-to-word packer: drains the byte FIFO, builds 35-bit little-endian
// words into a holding register feeding the word FIFO, and reports per-frame status.
module mac_rx_packer
  import mac_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1536
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bf_empty,
  output logic        bf_read,
  input  logic [10:0] bf_rdata,
  input  logic        wf_full,
  output logic        wf_write,
  output logic [34:0] wf_wdata,
  output logic        frm_done,
  output logic        frm_err,
  output logic [15:0] frm_len
);

  rx_state_e   state, state_d;
  logic [1:0]  cnt, cnt_d;
  logic [15:0] len, len_d;
  logic        err_q, err_d;
  logic [31:0] acc_q, acc_d;
  logic [34:0] hold, hold_d;
  logic        hvalid, hvalid_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [15:0] flen_q, flen_d;

  logic        sof, eof, berr, avail, free, at_limit;
  logic [7:0]  bbyte;
  logic [15:0] len_inc;
  logic [31:0] acc_wr;

  assign sof      = bf_rdata[BE_SOF];
  assign eof      = bf_rdata[BE_EOF];
  assign berr     = bf_rdata[BE_ERR];
  assign bbyte    = bf_rdata[7:0];
  assign avail    = !bf_empty;
  assign free     = !hvalid || !wf_full;
  assign len_inc  = len + 16'd1;
  assign at_limit = (len_inc == 16'(MAX_LEN)) && !eof;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    len_d    = len;
    err_d    = err_q;
    acc_d    = acc_q;
    hold_d   = hold;
    hvalid_d = hvalid && wf_full;
    done_d   = 1'b0;
    ferr_d   = 1'b0;
    flen_d   = flen_q;
    bf_read  = 1'b0;
    // acc_q is kept zero above slot cnt, so unused bytes of a loaded word are zero
    acc_wr   = acc_q;
    acc_wr[{cnt, 3'b000} +: 8] = bbyte;

    case (state)
      IDLE: begin
        if (avail && free) begin
          bf_read = 1'b1;
          if (sof) begin
            len_d = 16'd1;
            err_d = berr;
            if (eof) begin
              hold_d   = pack_word(1'b1, 2'd0, {24'h0, bbyte});
              hvalid_d = 1'b1;
              done_d   = 1'b1;
              ferr_d   = berr;
              flen_d   = 16'd1;
              cnt_d    = 2'd0;
              acc_d    = '0;
            end else begin
              acc_d   = {24'h0, bbyte};
              cnt_d   = 2'd1;
              state_d = ACC;
            end
          end
        end
      end

      ACC: begin
        if (avail && free) begin
          if (sof) begin
            // Abnormal close: the sof entry stays in the FIFO for IDLE to consume.
            hold_d   = pack_word(1'b1, (cnt == 2'd0) ? 2'd0 : cnt - 2'd1, acc_q);
            hvalid_d = 1'b1;
            done_d   = 1'b1;
            ferr_d   = 1'b1;
            flen_d   = len;
            cnt_d    = 2'd0;
            acc_d    = '0;
            state_d  = IDLE;
          end else begin
            bf_read = 1'b1;
            len_d   = len_inc;
            err_d   = err_q | berr;
            if (eof || at_limit || cnt == 2'd3) begin
              hold_d   = pack_word(eof || at_limit, cnt, acc_wr);
              hvalid_d = 1'b1;
              cnt_d    = 2'd0;
              acc_d    = '0;
              if (eof) begin
                done_d  = 1'b1;
                ferr_d  = err_q | berr;
                flen_d  = len_inc;
                state_d = IDLE;
              end else if (at_limit) begin
                done_d  = 1'b1;
                ferr_d  = 1'b1;
                flen_d  = 16'(MAX_LEN);
                state_d = DROP;
              end
            end else begin
              acc_d = acc_wr;
              cnt_d = cnt + 2'd1;
            end
          end
        end
      end

      DROP: begin
        if (avail) begin
          if (sof) state_d = IDLE;
          else     bf_read = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= '0;
      err_q  <= 1'b0;
      acc_q  <= '0;
      hold   <= '0;
      hvalid <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      flen_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      len    <= len_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
      hold   <= hold_d;
      hvalid <= hvalid_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      flen_q <= flen_d;
    end
  end

  assign wf_write = hvalid;
  assign wf_wdata = hold;
  assign frm_done = done_q;
  assign frm_err  = ferr_q;
  assign frm_len  = flen_q;

endmodule
